// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I single-cycle control unit: opcodes, control
// field enums and the decoded-control bundle.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } aluctl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_e;

  typedef struct packed {
    logic   reg_write;
    imm_e   imm_src;
    logic   alu_src;
    logic   mem_write;
    res_e   result_src;
    logic   branch;
    logic   jump;
    aluop_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: maps ALUOp plus funct3/funct7 (and op[5] to tell R-type sub
// from addi) onto the ALU operation select.
module alu_dec
  import ctrl_pkg::*;
(
  input  aluop_e      alu_op,
  input  logic [2:0]  funct3,
  input  logic        op5,
  input  logic        funct7,
  output aluctl_e     alu_ctl
);

  always_comb begin
    alu_ctl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctl = (op5 & funct7) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctl = ALU_SLT;
          3'b100:  alu_ctl = ALU_XOR;
          3'b110:  alu_ctl = ALU_OR;
          3'b111:  alu_ctl = ALU_AND;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ctrl_unit.sv
// RV32I single-cycle control unit: combinational main decode, branch/jump
// PC select, and an armed flop that holds off side effects out of reset.
module ctrl_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  output logic       PCSrc,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl
);

  logic    armed;
  ctrl_t   dec;
  aluctl_e alu_ctl;

  always_ff @(posedge clk) begin
    if (reset) armed <= 1'b0;
    else       armed <= 1'b1;
  end

  always_comb begin
    dec = '0;
    case (op)
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMM_I;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_MEM;
        dec.alu_op     = ALUOP_ADD;
      end
      OP_STORE: begin
        dec.imm_src    = IMM_S;
        dec.alu_src    = 1'b1;
        dec.mem_write  = 1'b1;
        dec.alu_op     = ALUOP_ADD;
      end
      OP_RTYPE: begin
        dec.reg_write  = 1'b1;
        dec.alu_op     = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        dec.imm_src    = IMM_B;
        dec.branch     = 1'b1;
        dec.alu_op     = ALUOP_SUB;
      end
      OP_IALU: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMM_I;
        dec.alu_src    = 1'b1;
        dec.alu_op     = ALUOP_FUNCT;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = IMM_J;
        dec.result_src = RES_PC4;
        dec.jump       = 1'b1;
      end
      default: dec = '0;
    endcase
  end

  alu_dec u_alu_dec (
    .alu_op  (dec.alu_op),
    .funct3  (funct3),
    .op5     (op[5]),
    .funct7  (funct7),
    .alu_ctl (alu_ctl)
  );

  // Architectural side effects are masked until the first edge out of reset.
  assign RegWrite   = armed & dec.reg_write;
  assign MemWrite   = armed & dec.mem_write;
  assign PCSrc      = armed & ((dec.branch & Zero) | dec.jump);
  assign ALUSrc     = dec.alu_src;
  assign ImmSrc     = dec.imm_src;
  assign ResultSrc  = dec.result_src;
  assign ALUControl = alu_ctl;

endmodule

// File: tb/tb_ctrl_unit.sv
// Bench for ctrl_unit: directed plan steps plus randomized instructions and
// reset pulses, checked against an instruction-level reference model.
module tb_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       Zero;
  logic       PCSrc, MemWrite, ALUSrc, RegWrite;
  logic [1:0] ImmSrc, ResultSrc;
  logic [2:0] ALUControl;

  int n_cmp = 0;
  int n_bad = 0;
  logic armed_m = 1'b0;

  ctrl_unit dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7),
    .Zero       (Zero),
    .PCSrc      (PCSrc),
    .MemWrite   (MemWrite),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl)
  );

  always #5 clk = ~clk;

  // Side-effect enable follows the reset level seen at each rising edge.
  always @(posedge clk) armed_m <= ~reset;

  typedef struct packed {
    logic       pcsrc, memw, alusrc, regw;
    logic [1:0] imm, res;
    logic [2:0] aluc;
  } exp_t;

  function automatic exp_t model(input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z, input logic arm);
    exp_t e;
    bit is_lw, is_sw, is_r, is_beq, is_i, is_jal;
    is_lw  = (o == 7'h03);
    is_sw  = (o == 7'h23);
    is_r   = (o == 7'h33);
    is_beq = (o == 7'h63);
    is_i   = (o == 7'h13);
    is_jal = (o == 7'h6f);
    e = '0;
    e.regw   = is_lw | is_r | is_i | is_jal;
    e.memw   = is_sw;
    e.alusrc = is_lw | is_sw | is_i;
    e.pcsrc  = (is_beq & z) | is_jal;
    if (is_sw)       e.imm = 2'd1;
    else if (is_beq) e.imm = 2'd2;
    else if (is_jal) e.imm = 2'd3;
    if (is_lw)       e.res = 2'd1;
    else if (is_jal) e.res = 2'd2;
    if (is_beq) e.aluc = 3'd1;
    else if (is_r || is_i) begin
      if (f3 == 3'd0)      e.aluc = (is_r && f7) ? 3'd1 : 3'd0;  // only R-type sub
      else if (f3 == 3'd2) e.aluc = 3'd5;
      else if (f3 == 3'd4) e.aluc = 3'd4;
      else if (f3 == 3'd6) e.aluc = 3'd3;
      else if (f3 == 3'd7) e.aluc = 3'd2;
    end
    if (!arm) begin
      e.regw = 1'b0; e.memw = 1'b0; e.pcsrc = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b (op=%b f3=%b f7=%b z=%b t=%0t)",
             tag, obs, exp, op, funct3, funct7, Zero, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    exp_t e;
    e = model(op, funct3, funct7, Zero, armed_m);
    chk({tag, ".PCSrc"},      {2'b0, PCSrc},     {2'b0, e.pcsrc});
    chk({tag, ".MemWrite"},   {2'b0, MemWrite},  {2'b0, e.memw});
    chk({tag, ".ALUSrc"},     {2'b0, ALUSrc},    {2'b0, e.alusrc});
    chk({tag, ".RegWrite"},   {2'b0, RegWrite},  {2'b0, e.regw});
    chk({tag, ".ImmSrc"},     {1'b0, ImmSrc},    {1'b0, e.imm});
    chk({tag, ".ResultSrc"},  {1'b0, ResultSrc}, {1'b0, e.res});
    chk({tag, ".ALUControl"}, ALUControl,        e.aluc);
  endtask

  task automatic step(input string tag, input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic z);
    @(negedge clk);
    op = o; funct3 = f3; funct7 = f7; Zero = z;
    #1;
    chk_all(tag);
  endtask

  initial begin
    reset = 1'b1; op = 7'b0100011; funct3 = 3'd0; funct7 = 1'b0; Zero = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst.MemWrite", {2'b0, MemWrite}, 3'd0);
    chk("rst.PCSrc",    {2'b0, PCSrc},    3'd0);
    chk("rst.ImmSrc",   {1'b0, ImmSrc},   3'd1);
    chk_all("rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("arm.MemWrite", {2'b0, MemWrite}, 3'd1);
    chk_all("arm");

    step("lw",      7'b0000011, 3'd2, 1'b0, 1'b0);
    chk("lw.ResultSrc", {1'b0, ResultSrc}, 3'd1);
    step("sw",      7'b0100011, 3'd2, 1'b1, 1'b0);
    step("beq_z1",  7'b1100011, 3'd0, 1'b0, 1'b1);
    chk("beq_z1.PCSrc",      {2'b0, PCSrc}, 3'd1);
    chk("beq_z1.ALUControl", ALUControl,    3'd1);
    step("beq_z0",  7'b1100011, 3'd0, 1'b0, 1'b0);
    chk("beq_z0.PCSrc",      {2'b0, PCSrc}, 3'd0);
    step("jal",     7'b1101111, 3'd5, 1'b1, 1'b0);
    chk("jal.PCSrc",         {2'b0, PCSrc}, 3'd1);
    step("addi_f7", 7'b0010011, 3'd0, 1'b1, 1'b0);
    chk("addi.ALUControl",   ALUControl,    3'd0);
    step("sub",     7'b0110011, 3'd0, 1'b1, 1'b1);
    chk("sub.ALUControl",    ALUControl,    3'd1);
    step("add",     7'b0110011, 3'd0, 1'b0, 1'b0);
    step("slt",     7'b0110011, 3'd2, 1'b0, 1'b0);
    chk("slt.ALUControl",    ALUControl,    3'd5);
    step("xor",     7'b0110011, 3'd4, 1'b0, 1'b0);
    step("or",      7'b0110011, 3'd6, 1'b0, 1'b0);
    step("and",     7'b0110011, 3'd7, 1'b0, 1'b0);
    chk("and.ALUControl",    ALUControl,    3'd2);
    step("r_f3_1",  7'b0110011, 3'd1, 1'b1, 1'b0);
    step("unknown", 7'b1111111, 3'd0, 1'b1, 1'b1);
    chk("unk.RegWrite",      {2'b0, RegWrite}, 3'd0);

    // Random instructions with occasional mid-stream reset pulses.
    for (int i = 0; i < 400; i++) begin
      logic [6:0] ops [6];
      logic [6:0] o;
      ops = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h13, 7'h6f};
      if ($urandom_range(0, 7) < 6) o = ops[$urandom_range(0, 5)];
      else                          o = 7'($urandom);
      @(negedge clk);
      reset  = ($urandom_range(0, 15) == 0);
      op     = o;
      funct3 = 3'($urandom);
      funct7 = 1'($urandom);
      Zero   = 1'($urandom);
      #1;
      chk_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_unit.md
Name: ctrl_unit

Overview:
- Control unit for the single-cycle RV32I core.
- Decodes opcode, funct3, funct7 bit 5 and the ALU Zero flag into datapath controls:
  - PC select
  - memory write
  - ALU operand select
  - register write
  - immediate format
  - result mux select
  - ALU operation
- Decode is purely combinational. One synchronous "armed" flop suppresses architectural side effects until the first clock edge after reset deasserts.

Parameters:
- None.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  7  instruction opcode, instr[6:0].
- funct3  input  3  instr[14:12].
- funct7  input  1  instr[30] (funct7 bit 5).
- Zero  input  1  ALU result-equals-zero flag.
- PCSrc  output  1  1 = PC takes branch/jump target; 0 = PC+4.
- MemWrite  output  1  data memory write enable.
- ALUSrc  output  1  ALU operand B: 0 = register rs2; 1 = immediate.
- RegWrite  output  1  register file write enable.
- ImmSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- ResultSrc  output  2  writeback source: 00 ALU, 01 memory, 10 PC+4.
- ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high.
- Armed flop:
  - reset high at a clk rising edge -> armed <= 0.
  - Otherwise, at each rising edge -> armed <= 1.
- Gating: while armed = 0, RegWrite, MemWrite and PCSrc are forced to 0. All other outputs follow decode.
- Latency: zero. Outputs settle combinationally from op, funct3, funct7 and Zero within the same cycle, with no clock edge needed once armed.
- Main decode, listed as RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, Jump, ALUOp:
  - lw 0000011: 1, 00, 1, 0, 01, 0, 0, 00.
  - sw 0100011: 0, 01, 1, 1, 00, 0, 0, 00.
  - R-type 0110011: 1, 00, 0, 0, 00, 0, 0, 10.
  - beq 1100011: 0, 10, 0, 0, 00, 1, 0, 01.
  - I-ALU 0010011: 1, 00, 1, 0, 00, 0, 0, 10.
  - jal 1101111: 1, 11, 0, 0, 10, 0, 1, 00.
  - Any other opcode: all controls 0, ALUOp 00. No writes, no PC redirect.
- PCSrc = armed & ((Branch & Zero) | Jump).
- ALU decode:
  - ALUOp 00 -> 000 (add).
  - ALUOp 01 -> 001 (sub).
  - ALUOp 10 -> by funct3:
    - 000 -> 001 (sub) if op[5] & funct7, else 000 (add). So addi always adds and R-type sub subtracts.
    - 010 -> 101 (slt).
    - 100 -> 100 (xor).
    - 110 -> 011 (or).
    - 111 -> 010 (and).
    - Other funct3 -> 000.
  - ALUOp 11 (unreachable) -> 000.
- Zero is ignored for every opcode except beq.
- funct3 and funct7 are ignored unless ALUOp = 10.
- No X propagation: every output is fully defined for every input value.
- Reset mid-operation: the write enables and PCSrc drop to 0 from the edge at which reset is sampled high. They resume at the first edge after reset is sampled low.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_IALU, OP_JAL;
  - enums for ALUOp, ALUControl, ImmSrc and ResultSrc encodings.
- One natural sub-module: alu_dec, mapping (ALUOp, funct3, op[5], funct7) to ALUControl.
- The main decoder, PCSrc logic and the armed flop stay in ctrl_unit.

Test Plan:
- Reset for 2 cycles, then one clock with reset low. Apply sw with Zero = 1: during reset MemWrite = 0 and PCSrc = 0; after arming MemWrite = 1.
- lw (op 0000011) -> RegWrite 1, ImmSrc 00, ALUSrc 1, MemWrite 0, ResultSrc 01, PCSrc 0, ALUControl 000.
- sw (op 0100011) -> RegWrite 0, ImmSrc 01, ALUSrc 1, MemWrite 1, PCSrc 0, ALUControl 000.
- beq (op 1100011):
  - Zero = 1 -> PCSrc 1, ImmSrc 10, ALUSrc 0, RegWrite 0, ALUControl 001.
  - Zero = 0 -> PCSrc 0.
- jal (op 1101111), Zero = 0 -> RegWrite 1, ImmSrc 11, MemWrite 0, ResultSrc 10, PCSrc 1.
- ALU decode:
  - addi (op 0010011, funct3 000, funct7 1) -> ALUControl 000, ALUSrc 1, ResultSrc 00.
  - R-type (op 0110011) with funct3/funct7 = 000/1 -> 001; 000/0 -> 000; 010 -> 101; 100 -> 100; 110 -> 011; 111 -> 010.
  - Unknown op 1111111 -> RegWrite 0, MemWrite 0, PCSrc 0.
